// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// master = fetch stage, slave = instruction memory.
interface if_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imemReq;
    logic [ADDR_W-1:0] imemAddr;
    logic              imemReady;
    logic              imemRespValid;
    logic [DATA_W-1:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemRespValid,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemRespValid,
        output imemData
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: one outstanding imem read, IF/ID holding register,
// decode back-pressure, flush with response draining, misaligned-PC fault.
module if_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    if_stage_if.master        imem,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instrPC,
    output logic [ADDR_W-1:0] pcPlus4,
    output logic              fetchFault,
    output logic              idValid,
    input  logic              idReady,
    input  logic              flush,
    output logic              pcAdvance
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] reqPC;
    logic              misaligned;
    logic              capture_mem;
    logic              capture_bad;

    assign misaligned = |pc[1:0];

    // Request and pcAdvance are decoded from state so the PC register updates on
    // the capture edge itself; this keeps the 3-cycle fetch loop.
    assign imem.imemReq  = ~reset & (state == REQ) & ~flush & ~misaligned;
    assign imem.imemAddr = pc;

    assign capture_mem = ~reset & (state == WAIT) & ~flush & imem.imemRespValid;
    assign capture_bad = ~reset & (state == REQ)  & ~flush & misaligned;
    assign pcAdvance   = capture_mem | capture_bad;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            reqPC      <= '0;
            instr      <= '0;
            instrPC    <= '0;
            pcPlus4    <= '0;
            fetchFault <= 1'b0;
            idValid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end

                REQ: begin
                    if (flush) begin
                        state <= REQ;
                    end else if (misaligned) begin
                        // Faulting fetch delivers a NOP tagged with the bad PC.
                        instr      <= '0;
                        instrPC    <= pc;
                        pcPlus4    <= pc + ADDR_W'(4);
                        fetchFault <= 1'b1;
                        idValid    <= 1'b1;
                        state      <= HOLD;
                    end else if (imem.imemReady) begin
                        reqPC <= pc;
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (flush) begin
                        // A response coinciding with the flush already retires the request.
                        state <= imem.imemRespValid ? REQ : DROP;
                    end else if (imem.imemRespValid) begin
                        instr      <= imem.imemData;
                        instrPC    <= reqPC;
                        pcPlus4    <= reqPC + ADDR_W'(4);
                        fetchFault <= 1'b0;
                        idValid    <= 1'b1;
                        state      <= HOLD;
                    end
                end

                DROP: begin
                    if (imem.imemRespValid) begin
                        state <= REQ;
                    end
                end

                HOLD: begin
                    if (flush || idReady) begin
                        idValid <= 1'b0;
                        state   <= REQ;
                    end
                end

                default: begin
                    state   <= IDLE;
                    idValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID words are queued when a response
// (or misaligned fetch) is driven and compared when the word appears at decode.
module tb_if_stage;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc4;
        logic              fault;
    } word_t;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instrPC;
    logic [ADDR_W-1:0] pcPlus4;
    logic              fetchFault;
    logic              idValid;
    logic              idReady;
    logic              flush;
    logic              pcAdvance;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    word_t       sb[$];

    if_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    if_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .pc        (pc),
        .imem      (bus.master),
        .instr     (instr),
        .instrPC   (instrPC),
        .pcPlus4   (pcPlus4),
        .fetchFault(fetchFault),
        .idValid   (idValid),
        .idReady   (idReady),
        .flush     (flush),
        .pcAdvance (pcAdvance)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] i, input logic [31:0] p, input logic f);
        word_t w;
        w.instr = i;
        w.pc    = p;
        w.pc4   = p + 32'd4;
        w.fault = f;
        sb.push_back(w);
    endtask

    task automatic pop_check(input string tag);
        word_t w;
        chk({tag, "_idValid"}, {31'b0, idValid}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            w = sb.pop_front();
            chk({tag, "_instr"},   instr,   w.instr);
            chk({tag, "_instrPC"}, instrPC, w.pc);
            chk({tag, "_pcPlus4"}, pcPlus4, w.pc4);
            chk({tag, "_fault"},   {31'b0, fetchFault}, {31'b0, w.fault});
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        pc = '0;
        idReady = 1'b0;
        flush = 1'b0;
        bus.imemReady = 1'b0;
        bus.imemRespValid = 1'b0;
        bus.imemData = '0;

        step();
        step();
        chk("rst_imemReq",   {31'b0, bus.imemReq}, 32'd0);
        chk("rst_imemAddr",  bus.imemAddr, 32'd0);
        chk("rst_instr",     instr, 32'd0);
        chk("rst_instrPC",   instrPC, 32'd0);
        chk("rst_pcPlus4",   pcPlus4, 32'd0);
        chk("rst_fault",     {31'b0, fetchFault}, 32'd0);
        chk("rst_idValid",   {31'b0, idValid}, 32'd0);
        chk("rst_pcAdvance", {31'b0, pcAdvance}, 32'd0);

        // Aligned fetch at 0, response one cycle after acceptance
        reset = 1'b0;
        bus.imemReady = 1'b1;
        idReady = 1'b1;
        #1 chk("idle_imemReq", {31'b0, bus.imemReq}, 32'd0);
        step();
        chk("req_imemReq",  {31'b0, bus.imemReq}, 32'd1);
        chk("req_imemAddr", bus.imemAddr, 32'd0);
        step();
        bus.imemReady = 1'b0;
        bus.imemRespValid = 1'b1;
        bus.imemData = 32'h8C010004;
        push_word(32'h8C010004, 32'h0, 1'b0);
        #1 chk("t1_pcAdvance", {31'b0, pcAdvance}, 32'd1);
        chk("t1_wait_imemReq", {31'b0, bus.imemReq}, 32'd0);
        step();
        bus.imemRespValid = 1'b0;
        pc = 32'h4;
        #1 chk("t1_hold_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        pop_check("t1");
        step();
        chk("t1_idValid_1cyc", {31'b0, idValid}, 32'd0);
        chk("t1_next_imemReq", {31'b0, bus.imemReq}, 32'd1);
        chk("t1_next_imemAddr", bus.imemAddr, 32'h4);

        // Back-pressure for 5 cycles
        bus.imemReady = 1'b1;
        idReady = 1'b0;
        step();
        bus.imemReady = 1'b0;
        bus.imemRespValid = 1'b1;
        bus.imemData = 32'h20020005;
        push_word(32'h20020005, 32'h4, 1'b0);
        #1 chk("t2_pcAdvance", {31'b0, pcAdvance}, 32'd1);
        step();
        bus.imemRespValid = 1'b0;
        bus.imemData = 32'h11111111;
        pc = 32'h8;
        #1 pop_check("t2");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_idValid",   {31'b0, idValid}, 32'd1);
            chk("bp_instr",     instr, 32'h20020005);
            chk("bp_instrPC",   instrPC, 32'h4);
            chk("bp_imemReq",   {31'b0, bus.imemReq}, 32'd0);
            chk("bp_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        end
        idReady = 1'b1;
        step();
        chk("bp_release_idValid", {31'b0, idValid}, 32'd0);

        // Flush in WAIT with the response in the same cycle
        bus.imemReady = 1'b1;
        step();
        bus.imemReady = 1'b0;
        flush = 1'b1;
        bus.imemRespValid = 1'b1;
        bus.imemData = 32'hDEADBEEF;
        pc = 32'h100;
        #1 chk("t3_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        step();
        flush = 1'b0;
        bus.imemRespValid = 1'b0;
        #1 chk("t3_idValid", {31'b0, idValid}, 32'd0);
        chk("t3_imemReq",  {31'b0, bus.imemReq}, 32'd1);
        chk("t3_imemAddr", bus.imemAddr, 32'h100);
        chk("t3_instr_kept", instr, 32'h20020005);

        // Flush in WAIT, response arrives later and is drained
        bus.imemReady = 1'b1;
        step();
        bus.imemReady = 1'b0;
        flush = 1'b1;
        pc = 32'h200;
        #1 chk("t4_flush_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        step();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("drop_imemReq",   {31'b0, bus.imemReq}, 32'd0);
            chk("drop_idValid",   {31'b0, idValid}, 32'd0);
            chk("drop_pcAdvance", {31'b0, pcAdvance}, 32'd0);
            step();
        end
        bus.imemRespValid = 1'b1;
        bus.imemData = 32'h0BAD0BAD;
        #1 chk("drop_resp_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        chk("drop_resp_imemReq", {31'b0, bus.imemReq}, 32'd0);
        step();
        bus.imemRespValid = 1'b0;
        #1 chk("t4_idValid", {31'b0, idValid}, 32'd0);
        chk("t4_imemReq",  {31'b0, bus.imemReq}, 32'd1);
        chk("t4_imemAddr", bus.imemAddr, 32'h200);

        // Misaligned PC: fault word, no memory transaction
        pc = 32'h6;
        bus.imemReady = 1'b1;
        #1 chk("t5_imemReq",   {31'b0, bus.imemReq}, 32'd0);
        chk("t5_pcAdvance", {31'b0, pcAdvance}, 32'd1);
        push_word(32'h0, 32'h6, 1'b1);
        step();
        pc = 32'hFFFFFFFC;
        #1 chk("t5_hold_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        chk("t5_hold_imemReq", {31'b0, bus.imemReq}, 32'd0);
        pop_check("t5");
        step();

        // Fetch at the top of the address space: pcPlus4 wraps
        chk("t6_imemReq", {31'b0, bus.imemReq}, 32'd1);
        step();
        bus.imemReady = 1'b0;
        bus.imemRespValid = 1'b1;
        bus.imemData = 32'h12345678;
        push_word(32'h12345678, 32'hFFFFFFFC, 1'b0);
        step();
        bus.imemRespValid = 1'b0;
        #1 pop_check("t6");
        chk("t6_wrap", pcPlus4, 32'h0);
        step();

        // Reset while in WAIT; late response afterwards is ignored
        bus.imemReady = 1'b1;
        step();
        bus.imemReady = 1'b0;
        reset = 1'b1;
        step();
        chk("rw_instr",   instr, 32'h0);
        chk("rw_instrPC", instrPC, 32'h0);
        chk("rw_pcPlus4", pcPlus4, 32'h0);
        chk("rw_idValid", {31'b0, idValid}, 32'd0);
        chk("rw_imemReq", {31'b0, bus.imemReq}, 32'd0);
        chk("rw_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        reset = 1'b0;
        bus.imemRespValid = 1'b1;
        bus.imemData = 32'hCAFEF00D;
        #1 chk("late_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        step();
        bus.imemRespValid = 1'b0;
        #1 chk("late_idValid", {31'b0, idValid}, 32'd0);
        chk("late_instr",   instr, 32'h0);
        chk("late_imemReq", {31'b0, bus.imemReq}, 32'd1);

        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS datapath, directly downstream of the program counter register. It issues a read of the current `pc` to instruction memory over a request/response handshake and holds the returned word in an IF/ID output register until decode accepts it. It returns `pcAdvance` and `pcPlus4` to the next-PC logic feeding the program counter. It supports decode back-pressure, pipeline flush (branch/jump redirect) and misaligned-PC detection. At most one memory request is outstanding.

## Interface
- `ADDR_W`, 32, address width of `pc` and `imemAddr`
- `DATA_W`, 32, instruction width
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `pc`  in  ADDR_W  current PC from the program counter register
- `imemReq`  out  1  read request valid
- `imemAddr`  out  ADDR_W  read address; equals `pc` while `imemReq`=1
- `imemReady`  in  1  memory accepts the request this cycle
- `imemRespValid`  in  1  read data valid
- `imemData`  in  DATA_W  read data
- `instr`  out  DATA_W  registered instruction to decode
- `instrPC`  out  ADDR_W  PC of `instr`
- `pcPlus4`  out  ADDR_W  `instrPC + 4`, modulo 2^ADDR_W
- `fetchFault`  out  1  `instr` came from a misaligned PC
- `idValid`  out  1  `instr`, `instrPC`, `pcPlus4` and `fetchFault` are valid
- `idReady`  in  1  decode consumes the word this cycle when `idValid`=1
- `flush`  in  1  discard the in-flight fetch and the held word
- `pcAdvance`  out  1  one-cycle pulse; next-PC logic must update `pc` on this edge

## Operation
- FSM states:
  - IDLE
    - Entered on reset.
    - Next cycle: REQ unconditionally.
  - REQ
    - `imemReq` = ~`flush`.
    - If `pc[1:0]` != 0: no request. Load `instr`=0 (NOP), `instrPC`=`pc`, `fetchFault`=1, pulse `pcAdvance`, go to HOLD.
    - Else if `imemReady` & ~`flush`: latch `reqPC`=`pc`, go to WAIT.
    - Else: stay in REQ.
  - WAIT
    - If `flush`: go to DROP. If `imemRespValid` is high in the same cycle, the response is discarded and the next state is REQ.
    - Else if `imemRespValid`: `instr`=`imemData`, `instrPC`=`reqPC`, `fetchFault`=0, pulse `pcAdvance`, go to HOLD.
  - DROP
    - Wait for `imemRespValid` and discard the data. Then go to REQ.
  - HOLD
    - `idValid`=1.
    - If `flush`: `idValid` goes to 0, go to REQ.
    - Else if `idReady`: go to REQ.
    - Else: hold. The output registers must not change.
- `idValid` is 1 only in HOLD.
- `pcAdvance` is 0 outside the capture cycle. It is never asserted in DROP or on a flushed cycle.
- `pc` is sampled only in REQ. Redirects arrive through `flush` plus a new `pc`.
- `flush` has priority over every event except `reset`.
- `pcPlus4` is registered together with `instrPC` and wraps at 2^ADDR_W (0xFFFFFFFC -> 0x00000000).
- `imemData` is ignored outside WAIT and DROP.

## Timing
- Reset values: `imemReq`=0, `imemAddr`=`pc` (combinational pass-through), `instr`=0, `instrPC`=0, `pcPlus4`=0, `fetchFault`=0, `idValid`=0, `pcAdvance`=0. State = IDLE.
- Reset asserted in any state, including WAIT or DROP, returns the FSM to IDLE next edge. A late response arriving after reset is ignored because the FSM is not in WAIT or DROP.
- Cycle timing, with the request accepted in cycle N:
  - Earliest response is cycle N+1.
  - Capture and `pcAdvance` occur on the edge ending the response cycle.
  - `idValid`=1 from cycle N+2.
  - Updated `pc` is visible in cycle N+2.
- With `idReady` held at 1, back-to-back throughput is one instruction per 3 cycles (REQ, WAIT, HOLD) at zero memory latency.
- Misaligned fetch: `idValid`=1 one cycle after REQ, with no memory transaction.

## Test plan
- Reset then aligned fetch:
  - Stimulus: hold `reset` 2 cycles, `pc`=0x00000000, `imemReady`=1, response 1 cycle later with 0x8C010004, `idReady`=1.
  - Required: `instr`=0x8C010004, `instrPC`=0, `pcPlus4`=4, a single `pcAdvance` pulse, `idValid` high for 1 cycle.
- Back-pressure:
  - Stimulus: `idReady`=0 for 5 cycles after capture of 0x20020005.
  - Required: `idValid` and `instr` stable for 5 cycles, no `imemReq`, no further `pcAdvance`.
- Flush in WAIT, response in the same cycle:
  - Stimulus: `flush` and `imemRespValid` with 0xDEADBEEF both high in WAIT.
  - Required: word discarded, no `pcAdvance`, `idValid`=0, `imemReq` high next cycle at the new `pc`.
- Flush in WAIT, response 3 cycles later:
  - Stimulus: `flush` in WAIT; response arrives 3 cycles later.
  - Required: FSM stays in DROP until the response, discards it, then returns to REQ. `idValid` stays 0 throughout.
- Misaligned PC:
  - Stimulus: `pc`=0x00000006.
  - Required: `imemReq` stays 0, `instr`=0, `fetchFault`=1, `instrPC`=6, `pcAdvance` pulses once.
- Wrap and reset mid-operation:
  - Stimulus: fetch at `pc`=0xFFFFFFFC.
  - Required: `pcPlus4`=0.
  - Stimulus: assert `reset` while in WAIT.
  - Required: all outputs return to their reset values next edge; a late response is ignored.
